// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the two-source AXI4 read-address arbiter.
// Holds FSM encodings, AXI burst/response constants and a state helper.
package axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssue0 = 2'd1,
        StIssue1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;

    function automatic arb_state_e issue_state(input logic src);
        return src ? StIssue1 : StIssue0;
    endfunction

endpackage

// File: rtl/axi_pending_ctr.sv
// Outstanding-burst counter for one source: counts accepted AR bursts minus
// completed R bursts, saturating at 0 and flagging an underflow.
module axi_pending_ctr
    import axi_rd_arbiter_pkg::*;
#(
    parameter int unsigned MAX_PENDING = 4,
    parameter int unsigned CW          = $clog2(MAX_PENDING + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          underflow
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d     = cnt_q;
        underflow = 1'b0;
        if (inc && !dec) begin
            if (cnt_q != CW'(MAX_PENDING)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (dec && !inc) begin
            if (cnt_q == '0) begin
                underflow = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign full  = (cnt_q >= CW'(MAX_PENDING));

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin merge of two AXI4 read sources onto one controller read port.
// AR is arbitrated through a registered FSM; R is routed back by the top ID bit.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int unsigned ADDRS       = 27,
    parameter int unsigned REQID       = 4,
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MAX_PENDING = 4
) (
    input  logic               clock,
    input  logic               reset_n,

    input  logic               s0_arvalid,
    output logic               s0_arready,
    input  logic [ADDRS-1:0]   s0_araddr,
    input  logic [REQID-1:0]   s0_arid,
    input  logic [7:0]         s0_arlen,
    input  logic [1:0]         s0_arburst,
    output logic               s0_rvalid,
    input  logic               s0_rready,
    output logic               s0_rlast,
    output logic [1:0]         s0_rresp,
    output logic [REQID-1:0]   s0_rid,
    output logic [WIDTH-1:0]   s0_rdata,

    input  logic               s1_arvalid,
    output logic               s1_arready,
    input  logic [ADDRS-1:0]   s1_araddr,
    input  logic [REQID-1:0]   s1_arid,
    input  logic [7:0]         s1_arlen,
    input  logic [1:0]         s1_arburst,
    output logic               s1_rvalid,
    input  logic               s1_rready,
    output logic               s1_rlast,
    output logic [1:0]         s1_rresp,
    output logic [REQID-1:0]   s1_rid,
    output logic [WIDTH-1:0]   s1_rdata,

    output logic               m_arvalid,
    input  logic               m_arready,
    output logic [ADDRS-1:0]   m_araddr,
    output logic [REQID:0]     m_arid,
    output logic [7:0]         m_arlen,
    output logic [1:0]         m_arburst,
    input  logic               m_rvalid,
    output logic               m_rready,
    input  logic               m_rlast,
    input  logic [1:0]         m_rresp,
    input  logic [REQID:0]     m_rid,
    input  logic [WIDTH-1:0]   m_rdata
);

    localparam int unsigned CntW = $clog2(MAX_PENDING + 1);

    arb_state_e         state_q, state_d;
    logic               m_arvalid_q, m_arvalid_d;
    logic [ADDRS-1:0]   m_araddr_q, m_araddr_d;
    logic [REQID:0]     m_arid_q, m_arid_d;
    logic [7:0]         m_arlen_q, m_arlen_d;
    logic [1:0]         m_arburst_q, m_arburst_d;
    logic               s0_arready_q, s0_arready_d;
    logic               s1_arready_q, s1_arready_d;
    logic               rr_last_q, rr_last_d;
    logic               err_q, err_d;

    logic [CntW-1:0]    pend0, pend1;
    logic               full0, full1, uf0, uf1;
    logic               elig0, elig1, grant_src;
    logic               ar_hs, r_done, r_sel;

    assign elig0     = s0_arvalid && !full0;
    assign elig1     = s1_arvalid && !full1;
    // Tie goes to whichever source did not win last time.
    assign grant_src = (elig0 && elig1) ? ~rr_last_q : elig1;

    assign ar_hs  = m_arvalid_q && m_arready;
    assign r_sel  = m_rid[REQID];
    assign r_done = m_rvalid && m_rready && m_rlast;

    always_comb begin
        state_d      = state_q;
        m_arvalid_d  = m_arvalid_q;
        m_araddr_d   = m_araddr_q;
        m_arid_d     = m_arid_q;
        m_arlen_d    = m_arlen_q;
        m_arburst_d  = m_arburst_q;
        s0_arready_d = 1'b0;
        s1_arready_d = 1'b0;
        rr_last_d    = rr_last_q;
        err_d        = err_q | uf0 | uf1;

        case (state_q)
            StIdle: begin
                if (elig0 || elig1) begin
                    state_d     = issue_state(grant_src);
                    m_arvalid_d = 1'b1;
                    rr_last_d   = grant_src;
                    if (grant_src) begin
                        m_araddr_d   = s1_araddr;
                        m_arid_d     = {1'b1, s1_arid};
                        m_arlen_d    = s1_arlen;
                        m_arburst_d  = s1_arburst;
                        s1_arready_d = 1'b1;
                    end else begin
                        m_araddr_d   = s0_araddr;
                        m_arid_d     = {1'b0, s0_arid};
                        m_arlen_d    = s0_arlen;
                        m_arburst_d  = s0_arburst;
                        s0_arready_d = 1'b1;
                    end
                end
            end
            StIssue0, StIssue1: begin
                if (m_arready) begin
                    state_d     = StIdle;
                    m_arvalid_d = 1'b0;
                end
            end
            default: begin
                state_d     = StIdle;
                m_arvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            m_arvalid_q  <= 1'b0;
            m_araddr_q   <= '0;
            m_arid_q     <= '0;
            m_arlen_q    <= '0;
            m_arburst_q  <= '0;
            s0_arready_q <= 1'b0;
            s1_arready_q <= 1'b0;
            rr_last_q    <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            m_arvalid_q  <= m_arvalid_d;
            m_araddr_q   <= m_araddr_d;
            m_arid_q     <= m_arid_d;
            m_arlen_q    <= m_arlen_d;
            m_arburst_q  <= m_arburst_d;
            s0_arready_q <= s0_arready_d;
            s1_arready_q <= s1_arready_d;
            rr_last_q    <= rr_last_d;
            err_q        <= err_d;
        end
    end

    axi_pending_ctr #(
        .MAX_PENDING (MAX_PENDING),
        .CW          (CntW)
    ) u_pend0 (
        .clock     (clock),
        .reset_n   (reset_n),
        .inc       (ar_hs && !m_arid_q[REQID]),
        .dec       (r_done && !r_sel),
        .count     (pend0),
        .full      (full0),
        .underflow (uf0)
    );

    axi_pending_ctr #(
        .MAX_PENDING (MAX_PENDING),
        .CW          (CntW)
    ) u_pend1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .inc       (ar_hs && m_arid_q[REQID]),
        .dec       (r_done && r_sel),
        .count     (pend1),
        .full      (full1),
        .underflow (uf1)
    );

    assign m_arvalid  = m_arvalid_q;
    assign m_araddr   = m_araddr_q;
    assign m_arid     = m_arid_q;
    assign m_arlen    = m_arlen_q;
    assign m_arburst  = m_arburst_q;
    assign s0_arready = s0_arready_q;
    assign s1_arready = s1_arready_q;

    // R path is purely combinational so it keeps flowing even while held in reset.
    assign m_rready  = r_sel ? s1_rready : s0_rready;
    assign s0_rvalid = m_rvalid && !r_sel;
    assign s1_rvalid = m_rvalid && r_sel;
    assign s0_rlast  = m_rlast;
    assign s1_rlast  = m_rlast;
    assign s0_rresp  = m_rresp;
    assign s1_rresp  = m_rresp;
    assign s0_rid    = m_rid[REQID-1:0];
    assign s1_rid    = m_rid[REQID-1:0];
    assign s0_rdata  = m_rdata;
    assign s1_rdata  = m_rdata;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter: reset, single request,
// contention, backpressure, saturation, simultaneous events, underflow, mid-issue reset.
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;

    logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
    logic [26:0] s0_araddr;
    logic [3:0]  s0_arid, s0_rid;
    logic [7:0]  s0_arlen;
    logic [1:0]  s0_arburst, s0_rresp;
    logic [31:0] s0_rdata;

    logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
    logic [26:0] s1_araddr;
    logic [3:0]  s1_arid, s1_rid;
    logic [7:0]  s1_arlen;
    logic [1:0]  s1_arburst, s1_rresp;
    logic [31:0] s1_rdata;

    logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [26:0] m_araddr;
    logic [4:0]  m_arid, m_rid;
    logic [7:0]  m_arlen;
    logic [1:0]  m_arburst, m_rresp;
    logic [31:0] m_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    axi_rd_arbiter #(
        .ADDRS       (27),
        .REQID       (4),
        .WIDTH       (32),
        .MAX_PENDING (4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .s0_arvalid (s0_arvalid),
        .s0_arready (s0_arready),
        .s0_araddr  (s0_araddr),
        .s0_arid    (s0_arid),
        .s0_arlen   (s0_arlen),
        .s0_arburst (s0_arburst),
        .s0_rvalid  (s0_rvalid),
        .s0_rready  (s0_rready),
        .s0_rlast   (s0_rlast),
        .s0_rresp   (s0_rresp),
        .s0_rid     (s0_rid),
        .s0_rdata   (s0_rdata),
        .s1_arvalid (s1_arvalid),
        .s1_arready (s1_arready),
        .s1_araddr  (s1_araddr),
        .s1_arid    (s1_arid),
        .s1_arlen   (s1_arlen),
        .s1_arburst (s1_arburst),
        .s1_rvalid  (s1_rvalid),
        .s1_rready  (s1_rready),
        .s1_rlast   (s1_rlast),
        .s1_rresp   (s1_rresp),
        .s1_rid     (s1_rid),
        .s1_rdata   (s1_rdata),
        .m_arvalid  (m_arvalid),
        .m_arready  (m_arready),
        .m_araddr   (m_araddr),
        .m_arid     (m_arid),
        .m_arlen    (m_arlen),
        .m_arburst  (m_arburst),
        .m_rvalid   (m_rvalid),
        .m_rready   (m_rready),
        .m_rlast    (m_rlast),
        .m_rresp    (m_rresp),
        .m_rid      (m_rid),
        .m_rdata    (m_rdata)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        s0_arvalid = 1'b0; s0_araddr = '0; s0_arid = '0; s0_arlen = '0;
        s0_arburst = BURST_INCR; s0_rready = 1'b1;
        s1_arvalid = 1'b0; s1_araddr = '0; s1_arid = '0; s1_arlen = '0;
        s1_arburst = BURST_INCR; s1_rready = 1'b1;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = RESP_OKAY;
        m_rid = '0; m_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        #12;
        n_checks++;
        if (m_arvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_arvalid: got %0h want 0", m_arvalid);
        end
        n_checks++;
        if ({s0_arready, s1_arready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_arready: got %0b want 00", {s0_arready, s1_arready});
        end
        n_checks++;
        if ({m_araddr, m_arid, m_arlen, m_arburst} !== 42'h0) begin
            n_fail++; $display("FAIL reset_payload: got %0h want 0",
                               {m_araddr, m_arid, m_arlen, m_arburst});
        end
        n_checks++;
        if ({dut.pend0, dut.pend1, dut.err_q} !== 7'h0) begin
            n_fail++; $display("FAIL reset_counters: got %0h want 0",
                               {dut.pend0, dut.pend1, dut.err_q});
        end
        // R path stays live while reset is held
        m_rvalid = 1'b1; m_rid = 5'h13; m_rdata = 32'hCAFE0001; s1_rready = 1'b0;
        #1;
        n_checks++;
        if ({s0_rvalid, s1_rvalid, s1_rid, m_rready} !== 7'b01_0011_0) begin
            n_fail++; $display("FAIL reset_rroute: got %0b want 0100110",
                               {s0_rvalid, s1_rvalid, s1_rid, m_rready});
        end
        n_checks++;
        if (s1_rdata !== 32'hCAFE0001) begin
            n_fail++; $display("FAIL reset_rdata: got %0h want cafe0001", s1_rdata);
        end
        clear_inputs();
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        s0_arvalid = 1'b1; s0_araddr = 27'h0; s0_arlen = 8'd3; s0_arid = 4'd2;
        m_arready = 1'b1;
        step();
        n_checks++;
        if ({m_arvalid, m_arid, m_arlen, m_arburst} !== {1'b1, 5'h02, 8'd3, BURST_INCR}) begin
            n_fail++; $display("FAIL single_ar: got v=%0b id=%0h len=%0d burst=%0b want 1 02 3 01",
                               m_arvalid, m_arid, m_arlen, m_arburst);
        end
        n_checks++;
        if ({s0_arready, s1_arready} !== 2'b10) begin
            n_fail++; $display("FAIL single_arready: got %0b want 10", {s0_arready, s1_arready});
        end
        step();
        s0_arvalid = 1'b0;
        n_checks++;
        if ({m_arvalid, s0_arready, dut.pend0} !== {1'b0, 1'b0, 3'd1}) begin
            n_fail++; $display("FAIL single_accept: got v=%0b rdy=%0b pend0=%0d want 0 0 1",
                               m_arvalid, s0_arready, dut.pend0);
        end
        for (int i = 0; i < 4; i++) begin
            m_rvalid = 1'b1; m_rid = 5'h02; m_rdata = 32'h1000 + i; m_rlast = (i == 3);
            #1;
            n_checks++;
            if ({s0_rvalid, s1_rvalid, m_rready, s0_rid, s0_rlast} !==
                {1'b1, 1'b0, 1'b1, 4'd2, (i == 3)}) begin
                n_fail++; $display("FAIL single_rbeat%0d: got v0=%0b v1=%0b rdy=%0b id=%0h last=%0b",
                                   i, s0_rvalid, s1_rvalid, m_rready, s0_rid, s0_rlast);
            end
            n_checks++;
            if (s0_rdata !== 32'h1000 + i) begin
                n_fail++; $display("FAIL single_rdata%0d: got %0h want %0h", i, s0_rdata, 32'h1000 + i);
            end
            step();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
        n_checks++;
        if (dut.pend0 !== 3'd0) begin
            n_fail++; $display("FAIL single_pend_done: got %0d want 0", dut.pend0);
        end
    endtask

    task automatic test_contention();
        logic [26:0] a0, a1;
        logic        exp_src;
        do_reset();
        a0 = 27'h100; a1 = 27'h2000;
        s0_arvalid = 1'b1; s0_arid = 4'h1; s1_arvalid = 1'b1; s1_arid = 4'h7;
        s0_araddr = a0; s1_araddr = a1;
        m_arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_src = k[0];
            step();
            n_checks++;
            if ({m_arvalid, m_arid[4], s0_arready, s1_arready} !== {1'b1, exp_src, ~exp_src, exp_src}) begin
                n_fail++; $display("FAIL contention_grant%0d: got v=%0b src=%0b rdy=%0b%0b want src %0b",
                                   k, m_arvalid, m_arid[4], s0_arready, s1_arready, exp_src);
            end
            n_checks++;
            if (m_araddr !== (exp_src ? a1 : a0)) begin
                n_fail++; $display("FAIL contention_addr%0d: got %0h want %0h",
                                   k, m_araddr, exp_src ? a1 : a0);
            end
            step();
            if (exp_src) begin a1 = a1 + 27'h40; s1_araddr = a1; end
            else begin a0 = a0 + 27'h40; s0_araddr = a0; end
        end
        n_checks++;
        if ({dut.pend0, dut.pend1} !== {3'd2, 3'd2}) begin
            n_fail++; $display("FAIL contention_pend: got %0d %0d want 2 2", dut.pend0, dut.pend1);
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        s0_arvalid = 1'b1; s0_araddr = 27'h0ABC; s0_arid = 4'h4; s0_arlen = 8'd1;
        s1_arvalid = 1'b1; s1_araddr = 27'h1234; s1_arid = 4'h3; s1_arlen = 8'd7;
        step();
        n_checks++;
        if ({m_arvalid, m_arid, s0_arready} !== {1'b1, 5'h04, 1'b1}) begin
            n_fail++; $display("FAIL bp_grant: got v=%0b id=%0h rdy0=%0b want 1 04 1",
                               m_arvalid, m_arid, s0_arready);
        end
        for (int c = 0; c < 5; c++) begin
            step();
            s0_arvalid = 1'b0; s0_araddr = 27'h7FFFFFF;
            n_checks++;
            if ({m_arvalid, m_araddr, m_arid, m_arlen, s0_arready, s1_arready} !==
                {1'b1, 27'h0ABC, 5'h04, 8'd1, 2'b00}) begin
                n_fail++; $display("FAIL bp_hold%0d: got v=%0b a=%0h id=%0h len=%0d rdy=%0b%0b",
                                   c, m_arvalid, m_araddr, m_arid, m_arlen, s0_arready, s1_arready);
            end
        end
        m_arready = 1'b1;
        step();
        n_checks++;
        if (m_arvalid !== 1'b0) begin
            n_fail++; $display("FAIL bp_accept: got %0b want 0", m_arvalid);
        end
        step();
        n_checks++;
        if ({m_arvalid, m_arid, m_arlen, s1_arready} !== {1'b1, 5'h13, 8'd7, 1'b1}) begin
            n_fail++; $display("FAIL bp_next_grant: got v=%0b id=%0h len=%0d rdy1=%0b want 1 13 7 1",
                               m_arvalid, m_arid, m_arlen, s1_arready);
        end
        step();
        s1_arvalid = 1'b0;
        n_checks++;
        if ({dut.pend0, dut.pend1} !== {3'd1, 3'd1}) begin
            n_fail++; $display("FAIL bp_pend: got %0d %0d want 1 1", dut.pend0, dut.pend1);
        end
        clear_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        s0_arvalid = 1'b1; s0_arid = 4'h6; m_arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if ({m_arvalid, s0_arready} !== 2'b11) begin
                n_fail++; $display("FAIL sat_grant%0d: got v=%0b rdy0=%0b want 11", k, m_arvalid, s0_arready);
            end
            step();
        end
        n_checks++;
        if (dut.pend0 !== 3'd4) begin
            n_fail++; $display("FAIL sat_pend_full: got %0d want 4", dut.pend0);
        end
        step();
        n_checks++;
        if ({m_arvalid, s0_arready} !== 2'b00) begin
            n_fail++; $display("FAIL sat_stall: got v=%0b rdy0=%0b want 00", m_arvalid, s0_arready);
        end
        s1_arvalid = 1'b1; s1_arid = 4'h9;
        step();
        n_checks++;
        if ({m_arvalid, m_arid, s1_arready, s0_arready} !== {1'b1, 5'h19, 2'b10}) begin
            n_fail++; $display("FAIL sat_other_src: got v=%0b id=%0h rdy1=%0b rdy0=%0b want 1 19 1 0",
                               m_arvalid, m_arid, s1_arready, s0_arready);
        end
        step();
        s1_arvalid = 1'b0;
        step();
        n_checks++;
        if ({m_arvalid, dut.pend0, dut.pend1} !== {1'b0, 3'd4, 3'd1}) begin
            n_fail++; $display("FAIL sat_still_blocked: got v=%0b p0=%0d p1=%0d want 0 4 1",
                               m_arvalid, dut.pend0, dut.pend1);
        end
        m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = 5'h06;
        step();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        n_checks++;
        if ({m_arvalid, dut.pend0} !== {1'b0, 3'd3}) begin
            n_fail++; $display("FAIL sat_rlast: got v=%0b p0=%0d want 0 3", m_arvalid, dut.pend0);
        end
        step();
        n_checks++;
        if ({m_arvalid, m_arid[4], s0_arready} !== 3'b101) begin
            n_fail++; $display("FAIL sat_resume: got v=%0b src=%0b rdy0=%0b want 1 0 1",
                               m_arvalid, m_arid[4], s0_arready);
        end
        step();
        n_checks++;
        if (dut.pend0 !== 3'd4) begin
            n_fail++; $display("FAIL sat_pend_refill: got %0d want 4", dut.pend0);
        end
        clear_inputs();
    endtask

    task automatic test_simultaneous();
        do_reset();
        s1_arvalid = 1'b1; s1_arid = 4'h5; m_arready = 1'b1;
        step();
        step();
        n_checks++;
        if (dut.pend1 !== 3'd1) begin
            n_fail++; $display("FAIL simul_pre: got %0d want 1", dut.pend1);
        end
        step();
        m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = 5'h15;
        #1;
        n_checks++;
        if ({m_arvalid, s1_rvalid, m_rready} !== 3'b111) begin
            n_fail++; $display("FAIL simul_setup: got v=%0b rv1=%0b rrdy=%0b want 111",
                               m_arvalid, s1_rvalid, m_rready);
        end
        step();
        m_rvalid = 1'b0; m_rlast = 1'b0; s1_arvalid = 1'b0;
        n_checks++;
        if ({dut.pend1, m_arvalid} !== {3'd1, 1'b0}) begin
            n_fail++; $display("FAIL simul_pend: got p1=%0d v=%0b want 1 0", dut.pend1, m_arvalid);
        end
    endtask

    task automatic test_underflow();
        n_checks++;
        if ({dut.pend0, dut.err_q} !== {3'd0, 1'b0}) begin
            n_fail++; $display("FAIL uf_pre: got p0=%0d err=%0b want 0 0", dut.pend0, dut.err_q);
        end
        m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = 5'h00;
        step();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        n_checks++;
        if ({dut.pend0, dut.err_q} !== {3'd0, 1'b1}) begin
            n_fail++; $display("FAIL uf_sticky: got p0=%0d err=%0b want 0 1", dut.pend0, dut.err_q);
        end
        step();
        n_checks++;
        if (dut.err_q !== 1'b1) begin
            n_fail++; $display("FAIL uf_hold: got %0b want 1", dut.err_q);
        end
    endtask

    task automatic test_reset_mid_issue();
        do_reset();
        s0_arvalid = 1'b1; m_arready = 1'b1;
        step();
        step();
        s0_arvalid = 1'b0;
        s1_arvalid = 1'b1; s1_arid = 4'h2; m_arready = 1'b0;
        step();
        step();
        n_checks++;
        if ({m_arvalid, m_arid[4], dut.pend0} !== {1'b1, 1'b1, 3'd1}) begin
            n_fail++; $display("FAIL mid_pre: got v=%0b src=%0b p0=%0d want 1 1 1",
                               m_arvalid, m_arid[4], dut.pend0);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({m_arvalid, s1_arready, dut.pend0, dut.pend1} !== {2'b00, 3'd0, 3'd0}) begin
            n_fail++; $display("FAIL mid_async: got v=%0b rdy1=%0b p0=%0d p1=%0d want 0 0 0 0",
                               m_arvalid, s1_arready, dut.pend0, dut.pend1);
        end
        #1;
        reset_n = 1'b1;
        s0_arvalid = 1'b1; m_arready = 1'b1;
        step();
        n_checks++;
        if ({m_arvalid, m_arid[4], s0_arready, s1_arready} !== 4'b1010) begin
            n_fail++; $display("FAIL mid_first_grant: got v=%0b src=%0b rdy=%0b%0b want 1 0 10",
                               m_arvalid, m_arid[4], s0_arready, s1_arready);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_saturation();
        test_simultaneous();
        test_underflow();
        test_reset_mid_issue();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
